// File: rtl/serializer_rr_scheduler_pkg.sv
// ============================================================================
// Module   : serializer_sched_pkg
// Purpose  : Shared state encoding and counter width helpers for the scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serializer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Counters are compared and cleared before they could reach value+1.
  function automatic int beat_cnt_w(input int num_words);
    return $clog2(num_words + 1);
  endfunction

  function automatic int timeout_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serializer_rr_scheduler_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker, searching upward from ptr+1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           any
);

  // Two passes: indices above the pointer first, then the wrapped-around ones.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i > int'(ptr))) begin
        grant[i] = 1'b1;
        grant_id = IDW'(i);
        any      = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i <= int'(ptr))) begin
        grant[i] = 1'b1;
        grant_id = IDW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/serializer_rr_scheduler.sv
// ============================================================================
// Module   : serializer_rr_scheduler
// Purpose  : Round-robin sharing of one serializer among NUM_REQ requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serializer_rr_scheduler
  import serializer_sched_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int NUM_WORDS = 4,
  parameter  int NUM_REQ   = 4,
  parameter  int TIMEOUT   = 16,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               i_reset_n,
  input  logic [NUM_REQ-1:0]                 i_enable,
  input  logic [NUM_REQ*WIDTH*NUM_WORDS-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  output logic [WIDTH*NUM_WORDS-1:0]         o_ser_data,
  output logic                               o_ser_dv,
  input  logic                               i_ser_dv,
  output logic                               o_busy,
  output logic [IDW-1:0]                     o_frame_id,
  output logic                               o_frame_done,
  output logic                               o_error
);

  localparam int c_frame_w = WIDTH * NUM_WORDS;
  localparam int c_beat_w  = beat_cnt_w(NUM_WORDS);
  localparam int c_to_w    = timeout_cnt_w(TIMEOUT);
  localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(NUM_WORDS - 1);
  localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDW-1:0]        r_ptr;
  logic [c_beat_w-1:0]   r_beat_cnt;
  logic [c_beat_w-1:0]   w_beat_nxt;
  logic [c_to_w-1:0]     r_to_cnt;
  logic [c_to_w-1:0]     w_to_nxt;
  logic [c_frame_w-1:0]  r_ser_data;
  logic                  r_ser_dv;
  logic [IDW-1:0]        r_frame_id;
  logic                  r_frame_done;
  logic                  w_done_nxt;
  logic                  r_error;
  logic                  w_err_nxt;

  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_grant;
  logic [IDW-1:0]        w_grant_id;
  logic                  w_any;
  logic                  w_xfer;
  logic [c_frame_w-1:0]  w_win_data;

  assign w_elig = i_req_valid & i_enable;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req      (w_elig),
    .ptr      (r_ptr),
    .grant    (w_grant),
    .grant_id (w_grant_id),
    .any      (w_any)
  );

  // Ready is forced low while reset is held, even though the state already reads IDLE.
  assign o_req_ready = (r_state == IDLE && i_reset_n && w_any) ? w_grant : '0;
  assign w_xfer      = |(o_req_ready & i_req_valid);

  always_comb begin
    w_win_data = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_grant[r]) begin
        w_win_data = i_req_data[r*c_frame_w +: c_frame_w];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_to_nxt    = r_to_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_ser_dv) w_err_nxt = 1'b1;
        if (w_xfer)   w_state_nxt = LOAD;
      end
      LOAD, STREAM: begin
        w_state_nxt = STREAM;
        // A beat is checked before the watchdog so a last beat on the limit completes.
        if (i_ser_dv) begin
          w_to_nxt = '0;
          if (r_beat_cnt == c_beat_last) begin
            w_done_nxt  = 1'b1;
            w_beat_nxt  = '0;
            w_state_nxt = IDLE;
          end else begin
            w_beat_nxt = r_beat_cnt + 1'b1;
          end
        end else if (r_to_cnt == c_to_last) begin
          w_err_nxt   = 1'b1;
          w_beat_nxt  = '0;
          w_to_nxt    = '0;
          w_state_nxt = IDLE;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr        <= IDW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_to_cnt     <= '0;
      r_ser_data   <= '0;
      r_ser_dv     <= 1'b0;
      r_frame_id   <= '0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_beat_cnt   <= w_beat_nxt;
      r_to_cnt     <= w_to_nxt;
      r_ser_dv     <= w_xfer;
      r_frame_done <= w_done_nxt;
      r_error      <= w_err_nxt;
      if (w_xfer) begin
        r_ser_data <= w_win_data;
        r_frame_id <= w_grant_id;
        r_ptr      <= w_grant_id;
      end
    end
  end

  assign o_ser_data   = r_ser_data;
  assign o_ser_dv     = r_ser_dv;
  assign o_busy       = (r_state != IDLE);
  assign o_frame_id   = r_frame_id;
  assign o_frame_done = r_frame_done;
  assign o_error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_serializer_rr_scheduler.sv
// ============================================================================
// Module   : tb_serializer_rr_scheduler
// Purpose  : Scoreboard bench with serializer/deserializer stub and RR model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serializer_rr_scheduler;

  localparam int WIDTH     = 8;
  localparam int NUM_WORDS = 4;
  localparam int NUM_REQ   = 4;
  localparam int TIMEOUT   = 16;
  localparam int FW        = WIDTH * NUM_WORDS;
  localparam int IDW       = $clog2(NUM_REQ);

  logic                      clk = 1'b0;
  logic                      i_reset_n;
  logic [NUM_REQ-1:0]        i_enable;
  logic [NUM_REQ*FW-1:0]     i_req_data;
  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic [FW-1:0]             o_ser_data;
  logic                      o_ser_dv;
  logic                      i_ser_dv;
  logic                      o_busy;
  logic [IDW-1:0]            o_frame_id;
  logic                      o_frame_done;
  logic                      o_error;

  always #5 clk = ~clk;

  serializer_rr_scheduler #(
    .WIDTH(WIDTH), .NUM_WORDS(NUM_WORDS), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_req_data(i_req_data),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .o_ser_data(o_ser_data),
    .o_ser_dv(o_ser_dv), .i_ser_dv(i_ser_dv), .o_busy(o_busy), .o_frame_id(o_frame_id),
    .o_frame_done(o_frame_done), .o_error(o_error)
  );

  typedef struct {
    int            cyc;
    int            id;
    logic [FW-1:0] data;
  } ev_t;

  ev_t q_load[$];
  ev_t q_done[$];
  ev_t q_err[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: whether a frame is in flight, last winner, beat/gap tallies.
  bit            m_idle  = 1'b1;
  int            m_last  = NUM_REQ - 1;
  int            m_fid   = 0;
  int            m_beats = 0;
  int            m_gap   = 0;
  logic [FW-1:0] m_data  = '0;

  logic [NUM_REQ-1:0] hs_seen = '0;

  int            pending [NUM_REQ];
  logic [FW-1:0] req_word[NUM_REQ];
  bit            rand_mode  = 1'b0;
  bit            drop_ok    = 1'b0;
  int            gap_mode   = 0;
  bit            stall_next = 1'b0;
  int            stall_k    = 2;
  bit            stray_req  = 1'b0;

  bit            stub_active = 1'b0;
  logic [FW-1:0] stub_word   = '0;
  int            stub_sent   = 0;
  int            stub_gap    = 0;
  int            stub_stop   = NUM_WORDS;
  logic [FW-1:0] deser_word  = '0;

  function automatic int rr_pick(input logic [NUM_REQ-1:0] e, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last + k) % NUM_REQ;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: advances on each clock edge from the bench-driven inputs only.
  always @(posedge clk) begin
    logic [NUM_REQ-1:0] e;
    int                 w;
    ev_t                ev;
    cyc++;
    if (!i_reset_n) begin
      m_idle = 1'b1; m_last = NUM_REQ - 1; m_fid = 0; m_beats = 0; m_gap = 0;
      q_load.delete(); q_done.delete(); q_err.delete();
    end else if (m_idle) begin
      e = i_req_valid & i_enable;
      w = rr_pick(e, m_last);
      if (w >= 0) begin
        m_last = w; m_fid = w; m_data = i_req_data[w*FW +: FW];
        m_idle = 1'b0; m_beats = 0; m_gap = 0;
        ev.cyc = cyc; ev.id = w; ev.data = m_data;
        q_load.push_back(ev);
      end
      if (i_ser_dv) begin
        ev.cyc = cyc; ev.id = m_fid; ev.data = '0;
        q_err.push_back(ev);
      end
    end else begin
      if (i_ser_dv) begin
        m_beats++; m_gap = 0;
        if (m_beats == NUM_WORDS) begin
          ev.cyc = cyc; ev.id = m_fid; ev.data = m_data;
          q_done.push_back(ev);
          m_idle = 1'b1;
        end
      end else begin
        m_gap++;
        if (m_gap == TIMEOUT) begin
          ev.cyc = cyc; ev.id = m_fid; ev.data = '0;
          q_err.push_back(ev);
          m_idle = 1'b1;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model and scoreboard queues.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_rdy;
    int                 w;
    ev_t                ev;
    if (!i_reset_n) begin
      hs_seen = '0;
    end else begin
      hs_seen = o_req_ready & i_req_valid;
      exp_rdy = '0;
      if (m_idle) begin
        w = rr_pick(i_req_valid & i_enable, m_last);
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      chk("req_ready", 64'(o_req_ready), 64'(exp_rdy));
      chk("busy", 64'(o_busy), 64'(!m_idle));
      if (o_ser_dv) begin
        if (q_load.size() == 0) chk("ser_dv_unexpected", 64'(o_ser_dv), 64'd0);
        else begin
          ev = q_load.pop_front();
          chk("load_cycle", 64'(cyc), 64'(ev.cyc));
          chk("load_id", 64'(o_frame_id), 64'(ev.id));
          chk("load_data", 64'(o_ser_data), 64'(ev.data));
        end
      end
      if (o_frame_done) begin
        if (q_done.size() == 0) chk("done_unexpected", 64'(o_frame_done), 64'd0);
        else begin
          ev = q_done.pop_front();
          chk("done_cycle", 64'(cyc), 64'(ev.cyc));
          chk("done_id", 64'(o_frame_id), 64'(ev.id));
          chk("deser_word", 64'(deser_word), 64'(ev.data));
        end
      end
      if (o_error) begin
        if (q_err.size() == 0) chk("error_unexpected", 64'(o_error), 64'd0);
        else begin
          ev = q_err.pop_front();
          chk("error_cycle", 64'(cyc), 64'(ev.cyc));
          chk("error_id", 64'(o_frame_id), 64'(ev.id));
        end
      end
      if (q_load.size() != 0 && q_load[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL load_missing: no o_ser_dv, expected at cycle %0d, now %0d", q_load[0].cyc, cyc);
        void'(q_load.pop_front());
      end
      if (q_done.size() != 0 && q_done[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL done_missing: no o_frame_done, expected at cycle %0d, now %0d", q_done[0].cyc, cyc);
        void'(q_done.pop_front());
      end
      if (q_err.size() != 0 && q_err[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL error_missing: no o_error, expected at cycle %0d, now %0d", q_err[0].cyc, cyc);
        void'(q_err.pop_front());
      end
    end
  end

  function automatic int pick_gap();
    case (gap_mode)
      0:       return int'($urandom_range(3));
      1:       return TIMEOUT - 1;
      default: return ($urandom_range(7) == 0) ? TIMEOUT - 1 : int'($urandom_range(3));
    endcase
  endfunction

  // One cycle of stimulus: requesters, serializer stub (zero-latency capable), stray beats.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (hs_seen[r]) begin
        pending[r]--;
        req_word[r] = FW'($urandom);
      end
      if (rand_mode && pending[r] == 0 && $urandom_range(7) == 0) begin
        pending[r] = int'($urandom_range(3, 1));
        if ($urandom_range(19) == 0) begin
          stall_next = 1'b1;
          stall_k    = int'($urandom_range(NUM_WORDS - 1, 1));
        end
      end
    end
    if (rand_mode && $urandom_range(15) == 0) i_enable = NUM_REQ'($urandom);
    if (rand_mode && $urandom_range(31) == 0) stray_req = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) begin
      i_req_valid[r] = (pending[r] > 0) && !(drop_ok && $urandom_range(9) == 0);
      i_req_data[r*FW +: FW] = req_word[r];
    end
    i_ser_dv = 1'b0;
    if (!stub_active && o_ser_dv) begin
      stub_active = 1'b1;
      stub_word   = o_ser_data;
      stub_sent   = 0;
      stub_gap    = pick_gap();
      stub_stop   = stall_next ? stall_k : NUM_WORDS;
      stall_next  = 1'b0;
      deser_word  = '0;
    end
    if (stub_active) begin
      if (stub_sent == stub_stop) begin
        stub_active = 1'b0;
      end else if (stub_gap > 0) begin
        stub_gap--;
      end else begin
        i_ser_dv = 1'b1;
        deser_word[stub_sent*WIDTH +: WIDTH] = stub_word[stub_sent*WIDTH +: WIDTH];
        stub_sent++;
        if (stub_sent == NUM_WORDS) stub_active = 1'b0;
        else stub_gap = pick_gap();
      end
    end
    if (stray_req && !stub_active && m_idle && !i_ser_dv) begin
      i_ser_dv  = 1'b1;
      stray_req = 1'b0;
    end
  endtask

  function automatic bit quiet();
    for (int r = 0; r < NUM_REQ; r++) if (pending[r] != 0) return 1'b0;
    return m_idle && !stub_active && !stray_req;
  endfunction

  task automatic run_quiet(input int max_cyc, input string tag);
    int n = 0;
    while (!quiet()) begin
      tick();
      n++;
      if (n > max_cyc) begin
        checks++; errors++;
        $display("FAIL %s_timeout: still busy after %0d cycles", tag, n);
        break;
      end
    end
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},    64'(o_req_ready),  64'd0);
    chk({tag, "_ser_dv"},   64'(o_ser_dv),     64'd0);
    chk({tag, "_busy"},     64'(o_busy),       64'd0);
    chk({tag, "_frame_id"}, 64'(o_frame_id),   64'd0);
    chk({tag, "_ser_data"}, 64'(o_ser_data),   64'd0);
    chk({tag, "_done"},     64'(o_frame_done), 64'd0);
    chk({tag, "_error"},    64'(o_error),      64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_reset_n = 1'b0; i_enable = '1; i_req_valid = '0; i_req_data = '0; i_ser_dv = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      pending[r] = 0; req_word[r] = '0;
    end
    repeat (3) tick();
    i_req_valid = '1;
    #1;
    check_all_zero("reset");
    tick();
    i_reset_n = 1'b1;
    repeat (2) tick();

    req_word[1] = 32'h12345678; pending[1] = 1;
    run_quiet(200, "single");

    for (int r = 0; r < NUM_REQ; r++) begin
      req_word[r] = FW'(32'hA0 + r); pending[r] = 2;
    end
    run_quiet(400, "fairness");

    i_enable = 4'b1010;
    for (int r = 0; r < NUM_REQ; r++) pending[r] = 3;
    repeat (150) tick();
    chk("mask_r0_held", 64'(pending[0]), 64'd3);
    chk("mask_r2_held", 64'(pending[2]), 64'd3);
    chk("mask_r1_drained", 64'(pending[1]), 64'd0);
    chk("mask_r3_drained", 64'(pending[3]), 64'd0);
    i_enable = '1;
    run_quiet(400, "mask_drain");

    stall_next = 1'b1; stall_k = 2; pending[0] = 1;
    run_quiet(200, "timeout");
    pending[3] = 1;
    run_quiet(200, "after_timeout");

    stray_req = 1'b1;
    repeat (4) tick();

    gap_mode = 1; pending[2] = 1;
    run_quiet(300, "boundary");
    gap_mode = 0;

    rand_mode = 1'b1; drop_ok = 1'b1; gap_mode = 2;
    repeat (3000) tick();
    rand_mode = 1'b0; drop_ok = 1'b0; gap_mode = 0; i_enable = '1;
    run_quiet(3000, "random_drain");

    pending[0] = 1;
    n = 0;
    while (!(!m_idle && m_beats >= 2) && n < 100) begin
      tick();
      n++;
    end
    chk("midframe_reached", 64'(m_beats >= 2 && !m_idle), 64'd1);
    #1;
    i_reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    stub_active = 1'b0; i_ser_dv = 1'b0; stall_next = 1'b0; stray_req = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) pending[r] = 0;
    repeat (2) tick();
    i_reset_n = 1'b1;
    tick();
    req_word[2] = 32'h9abcdef0; pending[2] = 1;
    run_quiet(200, "after_reset");

    chk("queues_empty", 64'(q_load.size() + q_done.size() + q_err.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serializer_rr_scheduler.md
Name: serializer_rr_scheduler

Overview:
Shares one serializer instance among NUM_REQ parallel-word requesters.
- Arbitrates round-robin among enabled, valid requesters.
- Loads the winner's word into the serializer with a one-cycle dv pulse.
- Counts the serialized beats coming back and reports frame completion with the source ID.
- A watchdog aborts a frame if the serializer stalls.

Parameters:
- WIDTH, 8, serial word width (matches serializer WIDTH).
- NUM_WORDS, 4, words per frame (matches serializer NUM_WORDS); must be >= 1.
- NUM_REQ, 4, number of requesters; must be >= 2.
- TIMEOUT, 16, max cycles between serializer beats in a frame before abort; must be >= 1.
- IDW, $clog2(NUM_REQ), localparam, requester ID width.

Ports:
- clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_enable  in  NUM_REQ  per-requester enable mask (configuration).
- i_req_data  in  NUM_REQ*WIDTH*NUM_WORDS  requester words; requester r occupies bits [r*WIDTH*NUM_WORDS +: WIDTH*NUM_WORDS].
- i_req_valid  in  NUM_REQ  requester holds its word valid until accepted.
- o_req_ready  out  NUM_REQ  one-hot, combinational accept; transfer occurs when valid&ready at a clk edge.
- o_ser_data  out  WIDTH*NUM_WORDS  word to serializer i_data; registered.
- o_ser_dv  out  1  one-cycle load pulse to serializer i_dv; registered.
- i_ser_dv  in  1  serializer o_dv; one pulse per serialized beat.
- o_busy  out  1  high from acceptance until frame done or abort.
- o_frame_id  out  IDW  requester ID of the current or last frame; registered.
- o_frame_done  out  1  one-cycle pulse after the NUM_WORDS-th beat.
- o_error  out  1  one-cycle pulse on timeout abort, or on a stray i_ser_dv in IDLE.

Behaviour:
- Reset (i_reset_n=0, async): state=IDLE; rr pointer=NUM_REQ-1; beat and timeout counters=0.
  - All outputs 0, o_ser_data=0, o_frame_id=0.
  - o_req_ready=0 while reset is asserted.
  - Reset mid-frame abandons the frame; the system resets the serializer from the same reset.
- Eligible set E = i_req_valid & i_enable.
- IDLE:
  - If E!=0, o_req_ready = one-hot of the first set bit of E searching upward from pointer+1 with wrap. Otherwise o_req_ready=0.
  - On a transfer edge: capture the winner's data into o_ser_data, winner ID into o_frame_id and the pointer; go to LOAD.
  - The pointer updates only on transfer.
- LOAD (1 cycle): o_ser_dv=1, o_busy=1, o_req_ready=0; go to STREAM next edge.
  - An i_ser_dv seen in LOAD is counted as a beat (zero-latency serializer).
- STREAM: o_busy=1, o_req_ready=0.
  - Each i_ser_dv increments the beat count and clears the timeout counter; otherwise the timeout counter increments.
  - Beat count reaching NUM_WORDS: o_frame_done pulse next cycle, counters cleared, return to IDLE.
  - Timeout counter reaching TIMEOUT: o_error pulse, counters cleared, return to IDLE; o_frame_id retained.
- Re-arbitration is allowed on the cycle after return to IDLE. Back-to-back frame latency from the last beat to the next o_ser_dv is 2 cycles.
- Enable masking and valid drop:
  - Deasserting i_enable[r] removes r from E immediately; no transfer occurs for r.
  - A valid dropped before ready causes no transfer and no pointer change.
- Stray i_ser_dv in IDLE: ignored for counting; o_error pulses.
- Simultaneous last beat and timeout on the same cycle: the beat wins (frame_done, no error).
- Counter widths: beat $clog2(NUM_WORDS+1); timeout $clog2(TIMEOUT+1). Neither wraps, since both are compared and cleared first.

Decomposition:
- Package serializer_sched_pkg: state enum {IDLE, LOAD, STREAM}; width helper functions for the beat and timeout counters.
- One sub-module, rr_arbiter:
  - Parameter N; inputs req[N], ptr[IDW]; outputs grant one-hot[N], grant_id[IDW], any.
  - Purely combinational rotate-priority-encode.
- FSM, counters and registers live in serializer_rr_scheduler.

Test Plan:
- Single request: r1 valid with 32'h12345678 -> ready[1] for 1 cycle; next cycle o_ser_dv=1, o_ser_data=32'h12345678, o_frame_id=1; after 4 serializer beats, o_frame_done pulse and o_busy=0.
- Fairness: r0..r3 all continuously valid with data 32'hA0..A3 -> grants in order 0,1,2,3,0; each frame feeds a serializer+deserializer chain and the deserializer o_data matches the source word.
- Enable mask: i_enable=4'b1010, all valid -> only IDs 1,3 granted, alternating; r0/r2 never see ready.
- Timeout: stub serializer emits 2 beats then stops, TIMEOUT=16 -> o_error at 16 idle cycles after the 2nd beat, return to IDLE, next request accepted.
- Reset mid-frame: assert i_reset_n=0 during STREAM after beat 2 -> outputs immediately 0; after release, a new r2 request with 32'h9abcdef0 completes normally with ID 2 (pointer reset).
- Stray beat and boundary: i_ser_dv pulse in IDLE -> o_error pulse, no state change; last beat coincident with the timeout limit -> o_frame_done, no o_error.
